// File: rtl/up_dwn_mod_cnt.sv
// Up/down counter over 0..max_val with wrap or saturate behaviour at the range ends,
// synchronous clamped load, terminal count, and sticky overflow/underflow flags.
module up_dwn_mod_cnt #(
    parameter int cnt_width = 5,
    parameter int max_val   = 2**cnt_width-1,
    parameter int sat_mode  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [cnt_width-1:0] load_val,
    input  logic                 clr_flags,
    output logic [cnt_width-1:0] count,
    output logic                 tc,
    output logic                 wrap_p,
    output logic                 ovf,
    output logic                 udf
);

    localparam logic [cnt_width:0] MAXV = (cnt_width+1)'(max_val);

    // Count register is one bit wider than the port so all arithmetic stays untruncated.
    logic [cnt_width:0] r_count;
    logic               r_wrap_p;
    logic               r_ovf;
    logic               r_udf;

    logic [cnt_width:0] w_next;
    logic [cnt_width:0] w_load_ext;
    logic               w_at_max;
    logic               w_at_zero;
    logic               w_event;
    logic               w_ovf_set;
    logic               w_udf_set;

    assign w_load_ext = {1'b0, load_val};
    assign w_at_max   = (r_count == MAXV);
    assign w_at_zero  = (r_count == '0);

    always_comb begin
        w_next    = r_count;
        w_event   = 1'b0;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        if (load) begin
            w_next = (w_load_ext > MAXV) ? MAXV : w_load_ext;
        end else if (en) begin
            if (up_dn) begin
                if (w_at_max) begin
                    w_next    = (sat_mode != 0) ? MAXV : '0;
                    w_event   = 1'b1;
                    w_ovf_set = 1'b1;
                end else begin
                    w_next = r_count + 1'b1;
                end
            end else begin
                if (w_at_zero) begin
                    w_next    = (sat_mode != 0) ? '0 : MAXV;
                    w_event   = 1'b1;
                    w_udf_set = 1'b1;
                end else begin
                    w_next = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_wrap_p <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_count  <= w_next;
            r_wrap_p <= w_event;
            // A flag set on the same edge as clr_flags takes precedence over the clear.
            r_ovf    <= w_ovf_set | (r_ovf & ~clr_flags);
            r_udf    <= w_udf_set | (r_udf & ~clr_flags);
        end
    end

    assign count  = r_count[cnt_width-1:0];
    assign tc     = (up_dn & w_at_max) | (~up_dn & w_at_zero);
    assign wrap_p = r_wrap_p;
    assign ovf    = r_ovf;
    assign udf    = r_udf;

endmodule
